// File: rtl/ghost_chase_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ghost_chase_ctrl
// Brief    : Per-frame ghost steering toward a scatter/chase target tile,
//            mode timer and sticky catch flag. GHOST_FRIGHT_EN adds the
//            frightened mode driven by power_pellet.
// Revision : 1.0
// ============================================================================
module ghost_chase_ctrl #(
  parameter int TILE           = 16,
  parameter int START_X        = 320,
  parameter int START_Y        = 240,
  parameter int SPEED          = 1,
  parameter int SCATTER_X      = 600,
  parameter int SCATTER_Y      = 8,
  parameter int SCATTER_FRAMES = 420,
  parameter int CHASE_FRAMES   = 1200,
  parameter int CATCH_DIST     = 8,
  parameter int FRIGHT_FRAMES  = 360
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic [9:0] pacX,
  input  logic [9:0] pacY,
  input  logic [3:0] wall_blk,
  input  logic       power_pellet,
  output logic [9:0] GhostX,
  output logic [9:0] GhostY,
  output logic [9:0] Ghost_X_Motion,
  output logic [9:0] Ghost_Y_Motion,
  output logic [1:0] ghost_mode,
  output logic       caught
);

  typedef enum logic [1:0] {SCATTER = 2'b00, CHASE = 2'b01, FRIGHT = 2'b10} modeT;
  // Encoding chosen so that reverse(dir) == dir ^ 2 and dir indexes wall_blk.
  typedef enum logic [1:0] {UP = 2'd0, LEFT = 2'd1, DOWN = 2'd2, RIGHT = 2'd3} dirT;

  localparam logic [9:0]  c_tile        = 10'(TILE);
  localparam logic [9:0]  c_half        = 10'(TILE / 2);
  localparam logic [9:0]  c_tileMask    = 10'(TILE - 1);
  localparam logic [9:0]  c_speed       = 10'(SPEED);
  localparam logic [9:0]  c_catchDist   = 10'(CATCH_DIST);
  localparam logic [9:0]  c_scatterX    = 10'(SCATTER_X);
  localparam logic [9:0]  c_scatterY    = 10'(SCATTER_Y);
  localparam logic [15:0] c_scatterLast = 16'(SCATTER_FRAMES - 1);
  localparam logic [15:0] c_chaseLast   = 16'(CHASE_FRAMES - 1);

  logic [9:0]  r_ghostX, r_ghostY, r_xMotion, r_yMotion;
  logic [9:0]  n_ghostX, n_ghostY, n_xMotion, n_yMotion;
  dirT         r_dir, n_dir;
  modeT        r_mode, n_mode;
  logic [15:0] r_modeTimer, n_modeTimer;
  logic        r_revPending, n_revPending;
  logic        r_caught, n_caught;

  logic        w_atCentre, w_inFright, w_revNow, w_move, w_overlap, w_found;
  logic [9:0]  w_tx, w_ty;
  logic [3:0]  w_cand;
  dirT         w_revDir, w_bestDir;
  logic [10:0] w_score, w_bestScore;

`ifdef GHOST_FRIGHT_EN
  modeT        r_prevMode, n_prevMode;
  logic [15:0] r_frightTimer, n_frightTimer;
  assign w_inFright = (r_mode == FRIGHT);
`else
  localparam int c_unusedFrightFrames = FRIGHT_FRAMES;
  logic w_unusedPellet;
  assign w_unusedPellet = power_pellet;
  assign w_inFright     = 1'b0;
`endif

  function automatic logic [9:0] absDiff(input logic [9:0] a, input logic [9:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  // Neighbour tile coordinates wrap like the tunnel, keeping each term 10 bits.
  function automatic logic [10:0] exitScore(input logic [1:0] d,
                                            input logic [9:0] gx, input logic [9:0] gy,
                                            input logic [9:0] tx, input logic [9:0] ty);
    logic [9:0] nx;
    logic [9:0] ny;
    nx = gx;
    ny = gy;
    case (d)
      2'd0:    ny = gy - c_tile;
      2'd1:    nx = gx - c_tile;
      2'd2:    ny = gy + c_tile;
      default: nx = gx + c_tile;
    endcase
    return {1'b0, absDiff(tx, nx)} + {1'b0, absDiff(ty, ny)};
  endfunction

  assign w_atCentre = ((r_ghostX & c_tileMask) == c_half) && ((r_ghostY & c_tileMask) == c_half);
  assign w_tx       = (r_mode == SCATTER) ? c_scatterX : pacX;
  assign w_ty       = (r_mode == SCATTER) ? c_scatterY : pacY;
  assign w_revDir   = dirT'(r_dir ^ 2'd2);

  always_comb begin
    w_cand = ~wall_blk;
    if (~wall_blk != (4'b0001 << w_revDir)) w_cand[w_revDir] = 1'b0;
  end

  always_comb begin
    w_found     = 1'b0;
    w_bestDir   = r_dir;
    w_bestScore = '0;
    w_score     = '0;
    for (int d = 0; d < 4; d++) begin
      w_score = exitScore(2'(d), r_ghostX, r_ghostY, w_tx, w_ty);
      if (w_cand[d] && (!w_found || (w_inFright ? (w_score > w_bestScore)
                                                : (w_score < w_bestScore)))) begin
        w_found     = 1'b1;
        w_bestDir   = dirT'(2'(d));
        w_bestScore = w_score;
      end
    end
  end

  always_comb begin
    n_ghostX     = r_ghostX;
    n_ghostY     = r_ghostY;
    n_xMotion    = r_xMotion;
    n_yMotion    = r_yMotion;
    n_dir        = r_dir;
    n_mode       = r_mode;
    n_modeTimer  = r_modeTimer;
    n_revPending = r_revPending;
    n_caught     = r_caught;
    w_revNow     = 1'b0;
    w_move       = 1'b0;
    w_overlap    = 1'b0;
`ifdef GHOST_FRIGHT_EN
    n_prevMode    = r_prevMode;
    n_frightTimer = r_frightTimer;
`endif
    if (!r_caught) begin
      w_revNow     = r_revPending;
      n_revPending = 1'b0;
      if (w_inFright) begin
`ifdef GHOST_FRIGHT_EN
        if (r_frightTimer <= 16'd1) begin
          n_mode        = r_prevMode;
          n_frightTimer = '0;
        end else begin
          n_frightTimer = r_frightTimer - 16'd1;
        end
`endif
      end else if (r_mode == CHASE) begin
        if (r_modeTimer == c_chaseLast) begin
          n_mode       = SCATTER;
          n_modeTimer  = '0;
          n_revPending = 1'b1;
        end else begin
          n_modeTimer = r_modeTimer + 16'd1;
        end
      end else begin
        if (r_modeTimer == c_scatterLast) begin
          n_mode       = CHASE;
          n_modeTimer  = '0;
          n_revPending = 1'b1;
        end else begin
          n_modeTimer = r_modeTimer + 16'd1;
        end
      end
`ifdef GHOST_FRIGHT_EN
      if (power_pellet) begin
        n_frightTimer = 16'(FRIGHT_FRAMES);
        if (!w_inFright) begin
          n_prevMode   = n_mode;
          n_mode       = FRIGHT;
          n_revPending = 1'b0;
          w_revNow     = 1'b1;
        end
      end
`endif

      if (w_revNow) begin
        n_dir  = w_revDir;
        w_move = 1'b1;
      end else if (w_atCentre) begin
        n_dir  = w_found ? w_bestDir : r_dir;
        w_move = w_found;
      end else begin
        w_move = 1'b1;
      end

      n_xMotion = '0;
      n_yMotion = '0;
      if (w_move) begin
        case (n_dir)
          UP:      n_yMotion = 10'd0 - c_speed;
          LEFT:    n_xMotion = 10'd0 - c_speed;
          DOWN:    n_yMotion = c_speed;
          default: n_xMotion = c_speed;
        endcase
      end
      n_ghostX = r_ghostX + n_xMotion;
      n_ghostY = r_ghostY + n_yMotion;

      w_overlap = (absDiff(pacX, n_ghostX) < c_catchDist) &&
                  (absDiff(pacY, n_ghostY) < c_catchDist);
`ifdef GHOST_FRIGHT_EN
      if (w_overlap && w_inFright) begin
        n_ghostX      = 10'(START_X);
        n_ghostY      = 10'(START_Y);
        n_xMotion     = '0;
        n_yMotion     = '0;
        n_dir         = LEFT;
        n_mode        = r_prevMode;
        n_frightTimer = '0;
        n_revPending  = 1'b0;
      end else if (w_overlap) begin
        n_caught = 1'b1;
      end
`else
      if (w_overlap) n_caught = 1'b1;
`endif
    end
  end

  always_ff @(posedge frame_clk or negedge Reset) begin
    if (!Reset) begin
      r_ghostX      <= 10'(START_X);
      r_ghostY      <= 10'(START_Y);
      r_xMotion     <= '0;
      r_yMotion     <= '0;
      r_dir         <= LEFT;
      r_mode        <= SCATTER;
      r_modeTimer   <= '0;
      r_revPending  <= 1'b0;
      r_caught      <= 1'b0;
`ifdef GHOST_FRIGHT_EN
      r_prevMode    <= SCATTER;
      r_frightTimer <= '0;
`endif
    end else begin
      r_ghostX      <= n_ghostX;
      r_ghostY      <= n_ghostY;
      r_xMotion     <= n_xMotion;
      r_yMotion     <= n_yMotion;
      r_dir         <= n_dir;
      r_mode        <= n_mode;
      r_modeTimer   <= n_modeTimer;
      r_revPending  <= n_revPending;
      r_caught      <= n_caught;
`ifdef GHOST_FRIGHT_EN
      r_prevMode    <= n_prevMode;
      r_frightTimer <= n_frightTimer;
`endif
    end
  end

  assign GhostX         = r_ghostX;
  assign GhostY         = r_ghostY;
  assign Ghost_X_Motion = r_caught ? 10'd0 : r_xMotion;
  assign Ghost_Y_Motion = r_caught ? 10'd0 : r_yMotion;
  assign ghost_mode     = r_mode;
  assign caught         = r_caught;

endmodule
`default_nettype wire

// File: tb/tb_ghost_chase_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ghost_chase_ctrl
// Brief    : Self-checking bench for ghost_chase_ctrl against a frame model.
// Revision : 1.0
// ============================================================================
module tb_ghost_chase_ctrl;

  localparam int TILE           = 16;
  localparam int START_X        = 328;
  localparam int START_Y        = 248;
  localparam int SPEED          = 1;
  localparam int SCATTER_X      = 600;
  localparam int SCATTER_Y      = 8;
  localparam int SCATTER_FRAMES = 420;
  localparam int CHASE_FRAMES   = 1200;
  localparam int CATCH_DIST     = 8;

  logic       frameClk = 1'b0;
  logic       rstN;
  logic [9:0] pacX, pacY;
  logic [3:0] wallBlk;
  logic       pellet;
  logic [9:0] ghostX, ghostY, xMot, yMot;
  logic [1:0] mode;
  logic       caught;

  int checks = 0;
  int errors = 0;

  // Frame-level model of the ghost
  int mX, mY, mDir, mMode, mTimer, mRev, mCaught, mDx, mDy;
  int dirDx[4] = '{0, -1, 0, 1};
  int dirDy[4] = '{-1, 0, 1, 0};

  ghost_chase_ctrl #(
    .TILE(TILE), .START_X(START_X), .START_Y(START_Y), .SPEED(SPEED),
    .SCATTER_X(SCATTER_X), .SCATTER_Y(SCATTER_Y), .SCATTER_FRAMES(SCATTER_FRAMES),
    .CHASE_FRAMES(CHASE_FRAMES), .CATCH_DIST(CATCH_DIST), .FRIGHT_FRAMES(360)
  ) dut (
    .frame_clk(frameClk), .Reset(rstN), .pacX(pacX), .pacY(pacY),
    .wall_blk(wallBlk), .power_pellet(pellet),
    .GhostX(ghostX), .GhostY(ghostY), .Ghost_X_Motion(xMot), .Ghost_Y_Motion(yMot),
    .ghost_mode(mode), .caught(caught)
  );

  always #5 frameClk = ~frameClk;

  function automatic int wrap(input int v);
    return ((v % 1024) + 1024) % 1024;
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic logic [9:0] expXm();
    return (mCaught != 0) ? 10'd0 : 10'(mDx);
  endfunction

  function automatic logic [9:0] expYm();
    return (mCaught != 0) ? 10'd0 : 10'(mDy);
  endfunction

  task automatic model_reset();
    mX = START_X; mY = START_Y; mDir = 1; mMode = 0; mTimer = 0;
    mRev = 0; mCaught = 0; mDx = 0; mDy = 0;
  endtask

  task automatic model_step();
    int tx, ty, best, bestScore, sc, nOpen, revDir;
    bit reverseNow, move;
    if (mCaught != 0) return;
    reverseNow = (mRev != 0);
    mRev = 0;
    tx = (mMode == 0) ? SCATTER_X : int'(pacX);
    ty = (mMode == 0) ? SCATTER_Y : int'(pacY);
    mTimer++;
    if (mMode == 0 && mTimer == SCATTER_FRAMES) begin
      mMode = 1; mTimer = 0; mRev = 1;
    end else if (mMode == 1 && mTimer == CHASE_FRAMES) begin
      mMode = 0; mTimer = 0; mRev = 1;
    end
    revDir = (mDir + 2) % 4;
    move = 1'b1;
    if (reverseNow) begin
      mDir = revDir;
    end else if (mX % TILE == TILE / 2 && mY % TILE == TILE / 2) begin
      nOpen = 0;
      for (int d = 0; d < 4; d++) if (!wallBlk[d]) nOpen++;
      best = -1;
      bestScore = 0;
      for (int d = 0; d < 4; d++) begin
        if (!wallBlk[d] && (d != revDir || nOpen == 1)) begin
          sc = iabs(tx - wrap(mX + dirDx[d] * TILE)) + iabs(ty - wrap(mY + dirDy[d] * TILE));
          if (best < 0 || sc < bestScore) begin
            best = d; bestScore = sc;
          end
        end
      end
      if (best >= 0) mDir = best;
      else move = 1'b0;
    end
    mDx = move ? dirDx[mDir] * SPEED : 0;
    mDy = move ? dirDy[mDir] * SPEED : 0;
    mX = wrap(mX + mDx);
    mY = wrap(mY + mDy);
    if (iabs(int'(pacX) - mX) < CATCH_DIST && iabs(int'(pacY) - mY) < CATCH_DIST) mCaught = 1;
  endtask

  task automatic tick();
    model_step();
    @(posedge frameClk);
    #1;
  endtask

  task automatic apply_reset();
    #2 rstN = 1'b0;
    #1 rstN = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    rstN = 1'b0; pacX = 10'd0; pacY = 10'd1000; wallBlk = 4'h0; pellet = 1'b0;
    repeat (2) @(posedge frameClk);
    #1;
    model_reset();
    checks++;
    if (ghostX !== 10'(START_X) || ghostY !== 10'(START_Y) || xMot !== 10'd0 ||
        yMot !== 10'd0 || mode !== 2'b00 || caught !== 1'b0) begin
      errors++;
      $display("FAIL reset_initial: got X=%0d Y=%0d xm=%h ym=%h mode=%0d caught=%0b, want %0d %0d 0 0 0 0",
               ghostX, ghostY, xMot, yMot, mode, caught, START_X, START_Y);
    end
    rstN = 1'b1;
    repeat (6) tick();
    #3 rstN = 1'b0;
    #1;
    checks++;
    if (ghostX !== 10'(START_X) || ghostY !== 10'(START_Y) || xMot !== 10'd0 ||
        yMot !== 10'd0 || mode !== 2'b00 || caught !== 1'b0) begin
      errors++;
      $display("FAIL reset_midframe: got X=%0d Y=%0d xm=%h ym=%h mode=%0d caught=%0b, want %0d %0d 0 0 0 0",
               ghostX, ghostY, xMot, yMot, mode, caught, START_X, START_Y);
    end
    #1 rstN = 1'b1;
    model_reset();
  endtask

  task automatic test_first_turn();
    apply_reset();
    wallBlk = 4'h0; pacX = 10'd0; pacY = 10'd1000;
    tick();
    checks++;
    if (ghostX !== 10'd328 || ghostY !== 10'd247) begin
      errors++;
      $display("FAIL first_turn_pos: got (%0d,%0d), want (328,247)", ghostX, ghostY);
    end
    checks++;
    if (xMot !== 10'd0 || yMot !== 10'h3FF) begin
      errors++;
      $display("FAIL first_turn_motion: got xm=%h ym=%h, want 000 3ff", xMot, yMot);
    end
  endtask

  task automatic test_walls();
    apply_reset();
    pacX = 10'd0; pacY = 10'd1000;
    wallBlk = 4'b0111;
    tick();
    checks++;
    if (xMot !== 10'd1 || ghostX !== 10'd329) begin
      errors++;
      $display("FAIL only_reverse_right: got X=%0d xm=%h, want 329 001", ghostX, xMot);
    end
    wallBlk = 4'h0;
    repeat (15) tick();
    wallBlk = 4'b1101;
    tick();
    checks++;
    if (xMot !== 10'h3FF || yMot !== 10'd0 || ghostX !== 10'd343) begin
      errors++;
      $display("FAIL only_reverse_left: got X=%0d xm=%h ym=%h, want 343 3ff 000", ghostX, xMot, yMot);
    end
    wallBlk = 4'h0;
    repeat (15) tick();
    wallBlk = 4'hF;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (xMot !== 10'd0 || yMot !== 10'd0 || ghostX !== 10'd328 || ghostY !== 10'd248) begin
        errors++;
        $display("FAIL all_blocked_hold[%0d]: got (%0d,%0d) xm=%h ym=%h, want (328,248) 0 0",
                 i, ghostX, ghostY, xMot, yMot);
      end
    end
  endtask

  task automatic test_wrap();
    apply_reset();
    pacX = 10'd500; pacY = 10'd1000;
    wallBlk = 4'b0101;
    for (int f = 1; f <= 329; f++) begin
      tick();
      checks++;
      if (ghostX !== 10'(mX) || ghostY !== 10'(mY) || xMot !== expXm() || yMot !== expYm()) begin
        errors++;
        $display("FAIL wrap_track f%0d: got (%0d,%0d) xm=%h ym=%h, want (%0d,%0d) xm=%h ym=%h",
                 f, ghostX, ghostY, xMot, yMot, mX, mY, expXm(), expYm());
      end
      if (f == 328) begin
        checks++;
        if (ghostX !== 10'd0) begin
          errors++;
          $display("FAIL wrap_reach_zero: got X=%0d, want 0", ghostX);
        end
      end
    end
    checks++;
    if (ghostX !== 10'd1023 || xMot !== 10'h3FF) begin
      errors++;
      $display("FAIL wrap_tunnel: got X=%0d xm=%h, want 1023 3ff", ghostX, xMot);
    end
  endtask

  task automatic test_catch();
    apply_reset();
    wallBlk = 4'h0; pacX = 10'd335; pacY = 10'd247;
    tick();
    checks++;
    if (caught !== 1'b1 || xMot !== 10'd0 || yMot !== 10'd0 || ghostY !== 10'd247) begin
      errors++;
      $display("FAIL catch_at_7: got caught=%0b xm=%h ym=%h Y=%0d, want 1 0 0 247",
               caught, xMot, yMot, ghostY);
    end
    repeat (3) tick();
    checks++;
    if (caught !== 1'b1 || ghostX !== 10'd328 || ghostY !== 10'd247 || yMot !== 10'd0) begin
      errors++;
      $display("FAIL catch_frozen: got caught=%0b (%0d,%0d) ym=%h, want 1 (328,247) 0",
               caught, ghostX, ghostY, yMot);
    end
    apply_reset();
    pacX = 10'd336; pacY = 10'd247;
    tick();
    checks++;
    if (caught !== 1'b0 || ghostY !== 10'd247 || yMot !== 10'h3FF) begin
      errors++;
      $display("FAIL no_catch_at_8: got caught=%0b Y=%0d ym=%h, want 0 247 3ff", caught, ghostY, yMot);
    end
  endtask

  task automatic test_scatter_timer();
    apply_reset();
    wallBlk = 4'h0; pacX = 10'd0; pacY = 10'd1000;
    for (int f = 1; f <= SCATTER_FRAMES + 1; f++) begin
      tick();
      checks++;
      if (ghostX !== 10'(mX) || ghostY !== 10'(mY) || xMot !== expXm() || yMot !== expYm() ||
          mode !== 2'(mMode)) begin
        errors++;
        $display("FAIL scatter_track f%0d: got (%0d,%0d) xm=%h ym=%h mode=%0d, want (%0d,%0d) xm=%h ym=%h mode=%0d",
                 f, ghostX, ghostY, xMot, yMot, mode, mX, mY, expXm(), expYm(), mMode);
      end
      if (f == SCATTER_FRAMES - 1) begin
        checks++;
        if (mode !== 2'b00) begin
          errors++;
          $display("FAIL scatter_before_switch: got mode=%0d, want 0", mode);
        end
      end
      if (f == SCATTER_FRAMES) begin
        checks++;
        if (mode !== 2'b01) begin
          errors++;
          $display("FAIL scatter_to_chase: got mode=%0d, want 1", mode);
        end
      end
    end
  endtask

  task automatic test_random_chase();
    apply_reset();
    for (int f = 1; f <= 1600; f++) begin
      if (f % 25 == 1) begin
        pacX = 10'($urandom_range(0, 639));
        pacY = 10'($urandom_range(0, 479));
      end
      if (iabs(int'(pacX) - mX) < 40 && iabs(int'(pacY) - mY) < 40) pacX = 10'(wrap(mX + 200));
      wallBlk = 4'($urandom & $urandom);
      pellet  = 1'($urandom_range(0, 15) == 0);
      tick();
      checks++;
      if (ghostX !== 10'(mX) || ghostY !== 10'(mY) || xMot !== expXm() || yMot !== expYm() ||
          mode !== 2'(mMode) || caught !== 1'(mCaught)) begin
        errors++;
        $display("FAIL random_track f%0d: got (%0d,%0d) xm=%h ym=%h mode=%0d c=%0b, want (%0d,%0d) xm=%h ym=%h mode=%0d c=%0d",
                 f, ghostX, ghostY, xMot, yMot, mode, caught, mX, mY, expXm(), expYm(), mMode, mCaught);
      end
    end
    pellet = 1'b0;
  endtask

  initial begin
    test_reset();
    test_first_turn();
    test_walls();
    test_wrap();
    test_catch();
    test_scatter_timer();
    test_random_chase();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
